// File: rtl/arbt_pkg.sv
// Shared types and helpers for the arbt_* dispatch/arbitration blocks.
package arbt_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } arbt_dsp_state_e;

    // Index width for a port count; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbt_dsp_onehot_dec.sv
// Binary-to-one-hot decoder used to build the initial pending-port mask.
module onehot_dec #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      onehot
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign onehot[i] = (addr == ADDR_WIDTH'(i));
    end

endmodule

// File: rtl/arbt_dsp.sv
// Fixed-destination dispatcher: accepts one item over rdy/ack and offers it to its
// decoded port over req/gnt. Broadcast items are enabled with ARBT_DSP_BCAST_EN.
module arbt_dsp
    import arbt_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ARBT_WIDTH = 4,
    parameter int unsigned           DEST_LSB   = 0,
    parameter int unsigned           BCAST_BIT  = DATA_WIDTH - 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rdy_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ARBT_WIDTH-1:0] req_o,
    input  logic [ARBT_WIDTH-1:0] gnt_i,
    output logic                  busy_o
);

    localparam int unsigned ADDR_WIDTH = addr_width(ARBT_WIDTH);

    arbt_dsp_state_e       state_q;
    logic [ARBT_WIDTH-1:0] pend_q;
    logic [ARBT_WIDTH-1:0] dec_mask;
    logic [ARBT_WIDTH-1:0] load_mask;
    logic [ARBT_WIDTH-1:0] pend_nxt;

    onehot_dec #(
        .WIDTH     (ARBT_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_dec (
        .addr  (data_i[DEST_LSB +: ADDR_WIDTH]),
        .onehot(dec_mask)
    );

`ifdef ARBT_DSP_BCAST_EN
    assign load_mask = data_i[BCAST_BIT] ? '1 : dec_mask;
`else
    assign load_mask = dec_mask;
`endif

    // Grants on ports that are not pending simply fall out of the AND.
    assign pend_nxt = pend_q & ~gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pend_q  <= '0;
            data_o  <= RESET_VAL;
            ack_o   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rdy_i) begin
                        data_o  <= data_i;
                        ack_o   <= 1'b1;
                        pend_q  <= load_mask;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    pend_q <= pend_nxt;
                    if (pend_nxt == '0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // pend_q is only non-zero in SEND, so it drives the requests directly.
    assign req_o  = pend_q;
    assign busy_o = (state_q == SEND);

`ifndef SYNTHESIS
    a_params: assert property (@(posedge clk_i)
        (ARBT_WIDTH >= 2) && (ARBT_WIDTH == (32'd1 << ADDR_WIDTH)) && (BCAST_BIT < DATA_WIDTH));
`ifndef ARBT_DSP_BCAST_EN
    a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_o));
`endif
    a_ack_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni) ack_o |=> !ack_o);
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ($past(busy_o) && busy_o) |-> $stable(data_o));
`endif

endmodule

// File: tb/tb_arbt_dsp.sv
// Scoreboard bench for arbt_dsp: every accepted item is checked against its expected data/port mask.
module tb_arbt_dsp;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rdy_i = 1'b0;
    logic        ack_o;
    logic        busy_o;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [3:0]  req_o;
    logic [3:0]  gnt_i;
    logic [3:0]  gnt_man = '0;
    logic        auto_gnt = 1'b0;

    exp_t sb_q[$];
    exp_t sb_e;
    int   checks = 0;
    int   fails = 0;
    int   ack_cnt = 0;
    int   cyc = 0;
    bit   overlap = 1'b0;
    bit   dbl_ack = 1'b0;
    logic prev_ack = 1'b0;

    always #5 clk_i = ~clk_i;

    // In auto mode every consumer takes its item on the first possible edge.
    assign gnt_i = auto_gnt ? req_o : gnt_man;

    arbt_dsp u_dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .data_i(data_i),
        .rdy_i (rdy_i),
        .ack_o (ack_o),
        .data_o(data_o),
        .req_o (req_o),
        .gnt_i (gnt_i),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input logic [31:0] d);
`ifdef ARBT_DSP_BCAST_EN
        if (d[31]) return 4'hF;
`endif
        return 4'b0001 << d[1:0];
    endfunction

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (req_o[1] && req_o[3]) overlap = 1'b1;
            if (prev_ack && ack_o) dbl_ack = 1'b1;
            if (ack_o) begin
                ack_cnt++;
                if (sb_q.size() == 0) begin
                    chk("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_data", data_o, sb_e.data);
                    chk("sb_req", {28'd0, req_o}, {28'd0, sb_e.mask});
                    chk("sb_busy", {31'd0, busy_o}, 32'd1);
                end
            end
        end
        prev_ack = rst_ni && ack_o;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present an item and return in the cycle where ack_o is visible.
    task automatic send(input logic [31:0] d);
        data_i = d;
        rdy_i  = 1'b1;
        sb_q.push_back('{data: d, mask: exp_mask(d)});
        for (int i = 0; i < 20; i++) begin
            step();
            if (ack_o) return;
        end
        chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c1, c2;
        #12;
        chk("rst_data", data_o, 32'd0);
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_req", {28'd0, req_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        #10 rst_ni = 1'b1;
        step();

        // single item to port 2, manual grant
        send(32'h0000_0002);
        rdy_i = 1'b0;
        chk("single_req", {28'd0, req_o}, 32'h4);
        chk("single_data", data_o, 32'h2);
        chk("single_ack", {31'd0, ack_o}, 32'd1);
        step();
        chk("single_ack_pulse", {31'd0, ack_o}, 32'd0);
        chk("single_hold", {28'd0, req_o}, 32'h4);
        gnt_man = 4'b0100;
        step();
        gnt_man = '0;
        chk("single_req_clr", {28'd0, req_o}, 32'd0);
        chk("single_idle", {31'd0, busy_o}, 32'd0);

        // stray grants, idle then while another port is pending
        gnt_man = 4'b0001;
        step();
        gnt_man = '0;
        chk("stray_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("stray_idle_req", {28'd0, req_o}, 32'd0);
        send(32'h0000_0006);
        rdy_i = 1'b0;
        gnt_man = 4'b0001;
        step();
        gnt_man = '0;
        chk("stray_send_req", {28'd0, req_o}, 32'h4);
        chk("stray_send_busy", {31'd0, busy_o}, 32'd1);
        gnt_man = 4'b0100;
        step();
        gnt_man = '0;
        chk("stray_send_done", {31'd0, busy_o}, 32'd0);

        // stale rdy held through the ack cycle
        auto_gnt = 1'b1;
        n = ack_cnt;
        send(32'h0000_0002);
        step();
        chk("stale_e1_idle", {31'd0, busy_o}, 32'd0);
        rdy_i = 1'b0;
        repeat (4) step();
        chk("stale_acks", ack_cnt - n, 32'd1);
        chk("stale_busy", {31'd0, busy_o}, 32'd0);

        // back-to-back with rdy continuously high
        send(32'h0000_0001);
        c1 = cyc;
        send(32'h0000_0003);
        c2 = cyc;
        rdy_i = 1'b0;
        chk("b2b_gap", c2 - c1, 32'd2);
        repeat (3) step();
        chk("b2b_idle", {31'd0, busy_o}, 32'd0);
        auto_gnt = 1'b0;

        // broadcast-flagged item
        send(32'h8000_0001);
        rdy_i = 1'b0;
`ifdef ARBT_DSP_BCAST_EN
        chk("bcast_req", {28'd0, req_o}, 32'hF);
        gnt_man = 4'b1000; step();
        chk("bcast_g3", {28'd0, req_o}, 32'h7);
        gnt_man = 4'b0001; step();
        chk("bcast_g0", {28'd0, req_o}, 32'h6);
        gnt_man = 4'b0010; step();
        chk("bcast_g1", {28'd0, req_o}, 32'h4);
        chk("bcast_busy", {31'd0, busy_o}, 32'd1);
        gnt_man = 4'b0100; step();
        chk("bcast_g2", {28'd0, req_o}, 32'h0);
`else
        chk("bcast_off_req", {28'd0, req_o}, 32'h2);
        gnt_man = 4'b0010; step();
        chk("bcast_off_clr", {28'd0, req_o}, 32'h0);
`endif
        gnt_man = '0;
        chk("bcast_idle", {31'd0, busy_o}, 32'd0);

        // asynchronous reset while port 3 is requested
        send(32'h0000_0003);
        rdy_i = 1'b0;
        step();
        chk("rst_pre_req", {28'd0, req_o}, 32'h8);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_mid_req", {28'd0, req_o}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mid_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_mid_data", data_o, 32'd0);
        #3 rst_ni = 1'b1;
        step();
        send(32'h0000_0001);
        rdy_i = 1'b0;
        chk("post_rst_req", {28'd0, req_o}, 32'h2);
        gnt_man = 4'b0010;
        step();
        gnt_man = '0;
        chk("post_rst_idle", {31'd0, busy_o}, 32'd0);

        step();
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("no_overlap", {31'd0, overlap}, 32'd0);
        chk("no_dbl_ack", {31'd0, dbl_ack}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
